// File: rtl/hps_spi_bridge_if.sv
// ============================================================================
//  Module      : hps_spi_bridge_if
//  Description : Signal bundle between the HPS-side SPI master / core logic
//                and the hps_spi_bridge SPI-slave bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hps_spi_bridge_if #(
    parameter int WORD_W = 16,
    parameter int IDX_W  = 8
);
    logic              spi_clk;
    logic              spi_cs;
    logic              spi_mosi;
    logic              spi_miso;
    logic              fpga_enable;
    logic              osd_enable;
    logic              io_enable;
    logic [WORD_W-1:0] gp_in;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_flush;
    logic [WORD_W+4:0] gp_out;
    logic [IDX_W-1:0]  rx_index;
    logic              io_strobe;
    logic              frame_start;
    logic              frame_end;

    // Bridge side
    modport slave (
        input  spi_clk, spi_cs, spi_mosi,
        input  fpga_enable, osd_enable, io_enable,
        input  gp_in, tx_data, tx_valid, tx_flush,
        output spi_miso, tx_ready, gp_out, rx_index,
        output io_strobe, frame_start, frame_end
    );

    // HPS / core side
    modport master (
        output spi_clk, spi_cs, spi_mosi,
        output fpga_enable, osd_enable, io_enable,
        output gp_in, tx_data, tx_valid, tx_flush,
        input  spi_miso, tx_ready, gp_out, rx_index,
        input  io_strobe, frame_start, frame_end
    );
endinterface

`default_nettype wire

// File: rtl/hps_spi_bridge.sv
// ============================================================================
//  Module      : hps_spi_bridge
//  Description : Mode-0 SPI-slave bridge between the HPS and the core.
//                Oversamples the SPI pins on sys_clk, receives words into
//                gp_out/rx_index with an io_strobe pulse, and transmits words
//                from a small TX FIFO, falling back to gp_in when it is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hps_spi_bridge #(
    parameter int WORD_W      = 16,
    parameter int TX_DEPTH    = 4,
    parameter int IDX_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            sys_clk,
    input  logic            reset,
    hps_spi_bridge_if.slave bus
);

    localparam int c_BIT_W = $clog2(WORD_W);
    localparam int c_PTR_W = $clog2(TX_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WORD_W - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(TX_DEPTH);
    localparam logic [IDX_W-1:0]   c_IDX_MAX  = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ---------------- synchroniser / edge detect ----------------
    // Bit order: {io_en, osd_en, fpga_en, mosi, cs, sck}
    logic [5:0]                  w_async;
    logic [SYNC_STAGES-1:0][5:0] r_sync;
    logic [5:0]                  w_synced;
    logic [1:0]                  r_ctl_d;   // previous synced {cs, sck}
    logic [2:0]                  r_en;      // enables, one stage past the synchroniser

    assign w_async  = {bus.io_enable, bus.osd_enable, bus.fpga_enable,
                       bus.spi_mosi, bus.spi_cs, bus.spi_clk};
    assign w_synced = r_sync[SYNC_STAGES-1];

    // Synchroniser chain plus the one-cycle history used for edge detection
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_ctl_d <= '0;
            r_en    <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_async};
            r_ctl_d <= w_synced[1:0];
            r_en    <= w_synced[5:3];
        end
    end

    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi;
    assign w_sck_rise =  w_synced[0] & ~r_ctl_d[0];
    assign w_sck_fall = ~w_synced[0] &  r_ctl_d[0];
    assign w_cs_fall  = ~w_synced[1] &  r_ctl_d[1];
    assign w_cs_rise  =  w_synced[1] & ~r_ctl_d[1];
    assign w_mosi     =  w_synced[2];

    // ---------------- frame FSM ----------------
    state_t r_state, w_state_next;
    logic   w_frame_start, w_frame_end, w_load, w_shift, w_rx_shift;
    logic   r_word_done;

    // State register
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state and per-cycle datapath strobes; CS rise beats any clock edge
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_rx_shift    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next  = ST_ACTIVE;
                    w_frame_start = 1'b1;
                    w_load        = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_frame_end  = 1'b1;
                end else begin
                    w_rx_shift = w_sck_rise;
                    if (w_sck_fall) begin
                        w_load  = r_word_done;
                        w_shift = ~r_word_done;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- TX FIFO ----------------
    logic [WORD_W-1:0]  r_mem [TX_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full, w_empty, w_push, w_pop;
    logic [WORD_W-1:0]  w_tx_word;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.tx_valid & ~w_full & ~bus.tx_flush;
    assign w_pop     = w_load & ~w_empty & ~bus.tx_flush;
    // A load while empty or flushing takes the default word instead
    assign w_tx_word = (~w_empty & ~bus.tx_flush) ? r_mem[r_rd_ptr] : bus.gp_in;

    // FIFO storage, pointers and occupancy; flush overrides push and pop
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TX_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.tx_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.tx_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push & ~w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (~w_push & w_pop) r_count <= r_count - c_CNT_W'(1);
        end
    end

    // ---------------- shifters and counters ----------------
    logic [WORD_W-2:0]  r_rx_sh;
    logic [WORD_W-1:0]  w_rx_next;
    logic [WORD_W-1:0]  r_rx_word;
    logic [WORD_W-1:0]  r_tx_sh;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [IDX_W-1:0]   r_word_cnt;
    logic [IDX_W-1:0]   r_rx_index;
    logic               r_strobe_pend, r_io_strobe;
    logic               w_last_bit;

    assign w_rx_next  = {r_rx_sh, w_mosi};
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // Receive/transmit shifting, word completion and strobe pipeline
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rx_sh       <= '0;
            r_rx_word     <= '0;
            r_tx_sh       <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_rx_index    <= '0;
            r_word_done   <= 1'b0;
            r_strobe_pend <= 1'b0;
            r_io_strobe   <= 1'b0;
        end else begin
            r_strobe_pend <= w_rx_shift & w_last_bit;
            r_io_strobe   <= r_strobe_pend;
            if (w_frame_start) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end
            if (w_rx_shift) begin
                r_rx_sh <= w_rx_next[WORD_W-2:0];
                if (w_last_bit) begin
                    r_bit_cnt   <= '0;
                    r_rx_word   <= w_rx_next;
                    r_rx_index  <= r_word_cnt;
                    r_word_done <= 1'b1;
                    if (r_word_cnt != c_IDX_MAX) r_word_cnt <= r_word_cnt + IDX_W'(1);
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
            end
            if (w_load) begin
                r_tx_sh     <= w_tx_word;
                r_word_done <= 1'b0;
            end else if (w_shift) begin
                r_tx_sh <= {r_tx_sh[WORD_W-2:0], 1'b0};
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.spi_miso    = (r_state == ST_ACTIVE) & r_tx_sh[WORD_W-1];
    assign bus.tx_ready    = ~w_full;
    assign bus.gp_out      = {r_en, 2'b00, r_rx_word};
    assign bus.rx_index    = r_rx_index;
    assign bus.io_strobe   = r_io_strobe;
    assign bus.frame_start = w_frame_start;
    assign bus.frame_end   = w_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_hps_spi_bridge.sv
// ============================================================================
//  Module      : tb_hps_spi_bridge
//  Description : Directed, self-checking bench for hps_spi_bridge. One
//                16-bit instance for the main behaviour and one 8-bit,
//                2-bit-index instance for index saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hps_spi_bridge;

    localparam int S    = 2;   // synchroniser depth of both instances
    localparam int HALF = 6;   // SPI half period in sys_clk cycles

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 sys_clk = ~sys_clk;

    hps_spi_bridge_if #(.WORD_W(16), .IDX_W(8)) bus_a ();
    hps_spi_bridge_if #(.WORD_W(8),  .IDX_W(2)) bus_b ();

    hps_spi_bridge #(.WORD_W(16), .TX_DEPTH(4), .IDX_W(8), .SYNC_STAGES(S)) dut_a (
        .sys_clk(sys_clk), .reset(reset), .bus(bus_a)
    );
    hps_spi_bridge #(.WORD_W(8), .TX_DEPTH(2), .IDX_W(2), .SYNC_STAGES(S)) dut_b (
        .sys_clk(sys_clk), .reset(reset), .bus(bus_b)
    );

    // ---------------- monitors ----------------
    int          n_strobe_a = 0, n_fs_a = 0, n_fe_a = 0, n_strobe_b = 0;
    logic [7:0]  idx_log_a [64];
    logic [15:0] rx_log_a  [64];
    logic [1:0]  idx_log_b [64];
    logic [7:0]  rx_log_b  [64];

    always @(negedge sys_clk) begin
        if (bus_a.io_strobe) begin
            if (n_strobe_a < 64) begin
                idx_log_a[n_strobe_a] <= bus_a.rx_index;
                rx_log_a[n_strobe_a]  <= bus_a.gp_out[15:0];
            end
            n_strobe_a <= n_strobe_a + 1;
        end
        if (bus_a.frame_start) n_fs_a <= n_fs_a + 1;
        if (bus_a.frame_end)   n_fe_a <= n_fe_a + 1;
        if (bus_b.io_strobe) begin
            if (n_strobe_b < 64) begin
                idx_log_b[n_strobe_b] <= bus_b.rx_index;
                rx_log_b[n_strobe_b]  <= bus_b.gp_out[7:0];
            end
            n_strobe_b <= n_strobe_b + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic spi_xfer_a(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus_a.spi_mosi = tx[15-i];
            wait_cyc(HALF);
            rx[15-i] = bus_a.spi_miso;
            bus_a.spi_clk = 1'b1;
            wait_cyc(HALF);
            bus_a.spi_clk = 1'b0;
        end
    endtask

    task automatic spi_xfer_b(input logic [7:0] tx, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < 8; i++) begin
            bus_b.spi_mosi = tx[7-i];
            wait_cyc(HALF);
            rx[7-i] = bus_b.spi_miso;
            bus_b.spi_clk = 1'b1;
            wait_cyc(HALF);
            bus_b.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_lo_a();
        bus_a.spi_cs = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_hi_a();
        wait_cyc(HALF);
        bus_a.spi_cs = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic push_a(input logic [15:0] d);
        bus_a.tx_data  = d;
        bus_a.tx_valid = 1'b1;
        wait_cyc(1);
        bus_a.tx_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] gp;
        logic [15:0] mosi;
        logic [15:0] exp_miso;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] rx;
    logic [7:0]  rxb;
    int          s0, fs0, fe0;

    initial begin
        vecs[0] = '{gp: 16'hA55A, mosi: 16'h1234, exp_miso: 16'hA55A, exp_rx: 16'h1234};
        vecs[1] = '{gp: 16'h0000, mosi: 16'hFFFF, exp_miso: 16'h0000, exp_rx: 16'hFFFF};
        vecs[2] = '{gp: 16'hFFFF, mosi: 16'h0000, exp_miso: 16'hFFFF, exp_rx: 16'h0000};
        vecs[3] = '{gp: 16'h8001, mosi: 16'h7FFE, exp_miso: 16'h8001, exp_rx: 16'h7FFE};
        vecs[4] = '{gp: 16'hC3C3, mosi: 16'h5AA5, exp_miso: 16'hC3C3, exp_rx: 16'h5AA5};

        bus_a.spi_clk = 0; bus_a.spi_cs = 1; bus_a.spi_mosi = 0;
        bus_a.fpga_enable = 0; bus_a.osd_enable = 0; bus_a.io_enable = 0;
        bus_a.gp_in = '0; bus_a.tx_data = '0; bus_a.tx_valid = 0; bus_a.tx_flush = 0;
        bus_b.spi_clk = 0; bus_b.spi_cs = 1; bus_b.spi_mosi = 0;
        bus_b.fpga_enable = 0; bus_b.osd_enable = 0; bus_b.io_enable = 0;
        bus_b.gp_in = '0; bus_b.tx_data = '0; bus_b.tx_valid = 0; bus_b.tx_flush = 0;

        // ---- reset state ----
        wait_cyc(3);
        chk("rst gp_out",      32'(bus_a.gp_out), 32'h0);
        chk("rst rx_index",    32'(bus_a.rx_index), 32'h0);
        chk("rst io_strobe",   32'(bus_a.io_strobe), 32'h0);
        chk("rst miso",        32'(bus_a.spi_miso), 32'h0);
        chk("rst tx_ready",    32'(bus_a.tx_ready), 32'h1);
        chk("rst frame_start", 32'(bus_a.frame_start), 32'h0);
        chk("rst frame_end",   32'(bus_a.frame_end), 32'h0);
        reset = 1'b0;
        wait_cyc(6);

        // ---- single-word frames, FIFO empty ----
        for (int v = 0; v < 5; v++) begin
            bus_a.gp_in = vecs[v].gp;
            s0 = n_strobe_a; fs0 = n_fs_a; fe0 = n_fe_a;
            cs_lo_a();
            spi_xfer_a(vecs[v].mosi, 16, rx);
            cs_hi_a();
            chk("vec miso",        32'(rx), 32'(vecs[v].exp_miso));
            chk("vec rx_word",     32'(bus_a.gp_out[15:0]), 32'(vecs[v].exp_rx));
            chk("vec rx_index",    32'(bus_a.rx_index), 32'h0);
            chk("vec strobes",     32'(n_strobe_a - s0), 32'd1);
            chk("vec frame_start", 32'(n_fs_a - fs0), 32'd1);
            chk("vec frame_end",   32'(n_fe_a - fe0), 32'd1);
        end

        // ---- queued responses then gp_in fallback, 3-word frame ----
        push_a(16'h0001);
        push_a(16'h0002);
        bus_a.gp_in = 16'hFFFF;
        s0 = n_strobe_a;
        cs_lo_a();
        spi_xfer_a(16'hA001, 16, rx); chk("q3 miso w0", 32'(rx), 32'h0001);
        spi_xfer_a(16'hB002, 16, rx); chk("q3 miso w1", 32'(rx), 32'h0002);
        spi_xfer_a(16'hC003, 16, rx); chk("q3 miso w2", 32'(rx), 32'hFFFF);
        cs_hi_a();
        chk("q3 strobes", 32'(n_strobe_a - s0), 32'd3);
        chk("q3 idx0", 32'(idx_log_a[s0]),   32'd0);
        chk("q3 idx1", 32'(idx_log_a[s0+1]), 32'd1);
        chk("q3 idx2", 32'(idx_log_a[s0+2]), 32'd2);
        chk("q3 rx0",  32'(rx_log_a[s0]),    32'hA001);
        chk("q3 rx1",  32'(rx_log_a[s0+1]),  32'hB002);
        chk("q3 rx2",  32'(rx_log_a[s0+2]),  32'hC003);

        // ---- FIFO full: extra push ignored, ready returns after one pop ----
        push_a(16'h0011);
        push_a(16'h0022);
        chk("fifo ready 2 words", 32'(bus_a.tx_ready), 32'h1);
        push_a(16'h0033);
        push_a(16'h0044);
        chk("fifo full ready", 32'(bus_a.tx_ready), 32'h0);
        push_a(16'h0055);
        chk("fifo full ready after 5th", 32'(bus_a.tx_ready), 32'h0);
        bus_a.gp_in  = 16'hBEEF;
        bus_a.spi_cs = 1'b0;
        wait_cyc(S);
        chk("fifo ready before pop", 32'(bus_a.tx_ready), 32'h0);
        wait_cyc(1);
        chk("fifo ready after pop", 32'(bus_a.tx_ready), 32'h1);
        wait_cyc(HALF - S - 1);
        spi_xfer_a(16'h0101, 16, rx); chk("full miso w0", 32'(rx), 32'h0011);
        spi_xfer_a(16'h0202, 16, rx); chk("full miso w1", 32'(rx), 32'h0022);
        spi_xfer_a(16'h0303, 16, rx); chk("full miso w2", 32'(rx), 32'h0033);
        spi_xfer_a(16'h0404, 16, rx); chk("full miso w3", 32'(rx), 32'h0044);
        spi_xfer_a(16'h0505, 16, rx); chk("full miso w4", 32'(rx), 32'hBEEF);
        cs_hi_a();

        // ---- flush beats a same-cycle push ----
        push_a(16'h7777);
        push_a(16'h8888);
        bus_a.tx_data  = 16'h9999;
        bus_a.tx_valid = 1'b1;
        bus_a.tx_flush = 1'b1;
        wait_cyc(1);
        bus_a.tx_valid = 1'b0;
        bus_a.tx_flush = 1'b0;
        bus_a.gp_in    = 16'h1357;
        cs_lo_a();
        spi_xfer_a(16'h2468, 16, rx);
        cs_hi_a();
        chk("flush miso",    32'(rx), 32'h1357);
        chk("flush rx_word", 32'(bus_a.gp_out[15:0]), 32'h2468);

        // ---- partial word discarded, next frame restarts index ----
        s0 = n_strobe_a; fe0 = n_fe_a;
        cs_lo_a();
        spi_xfer_a(16'hFFFF, 9, rx);
        cs_hi_a();
        chk("partial frame_end", 32'(n_fe_a - fe0), 32'd1);
        chk("partial strobes",   32'(n_strobe_a - s0), 32'd0);
        chk("partial rx_word",   32'(bus_a.gp_out[15:0]), 32'h2468);
        s0 = n_strobe_a;
        cs_lo_a();
        spi_xfer_a(16'h4321, 16, rx);
        cs_hi_a();
        chk("after partial strobes",  32'(n_strobe_a - s0), 32'd1);
        chk("after partial rx_index", 32'(bus_a.rx_index), 32'h0);
        chk("after partial rx_word",  32'(bus_a.gp_out[15:0]), 32'h4321);

        // ---- enable bits follow the pins S+1 cycles later ----
        bus_a.osd_enable = 1'b1;
        wait_cyc(S);
        chk("osd before", 32'(bus_a.gp_out[19]), 32'h0);
        wait_cyc(1);
        chk("osd after",  32'(bus_a.gp_out[19]), 32'h1);
        bus_a.io_enable = 1'b1;
        wait_cyc(S + 1);
        chk("enable bits", 32'(bus_a.gp_out[20:16]), 32'b11000);

        // ---- reset mid-word ----
        bus_a.gp_in = 16'h0F0F;
        cs_lo_a();
        spi_xfer_a(16'hABCD, 5, rx);
        reset = 1'b1;
        #1;
        chk("midrst gp_out",      32'(bus_a.gp_out), 32'h0);
        chk("midrst rx_index",    32'(bus_a.rx_index), 32'h0);
        chk("midrst io_strobe",   32'(bus_a.io_strobe), 32'h0);
        chk("midrst miso",        32'(bus_a.spi_miso), 32'h0);
        chk("midrst tx_ready",    32'(bus_a.tx_ready), 32'h1);
        chk("midrst frame_start", 32'(bus_a.frame_start), 32'h0);
        wait_cyc(2);
        reset = 1'b0;
        s0 = n_strobe_a; fs0 = n_fs_a; fe0 = n_fe_a;
        spi_xfer_a(16'hABCD, 16, rx);
        cs_hi_a();
        chk("postrst no strobe", 32'(n_strobe_a - s0), 32'd0);
        chk("postrst no start",  32'(n_fs_a - fs0), 32'd0);
        chk("postrst no end",    32'(n_fe_a - fe0), 32'd0);
        s0 = n_strobe_a;
        cs_lo_a();
        spi_xfer_a(16'h6A6A, 16, rx);
        cs_hi_a();
        chk("postrst miso",     32'(rx), 32'h0F0F);
        chk("postrst strobes",  32'(n_strobe_a - s0), 32'd1);
        chk("postrst rx_index", 32'(bus_a.rx_index), 32'h0);
        chk("postrst rx_word",  32'(bus_a.gp_out[15:0]), 32'h6A6A);

        // ---- 8-bit instance, 2-bit index saturates ----
        bus_b.gp_in = 8'h5A;
        s0 = n_strobe_b;
        bus_b.spi_cs = 1'b0;
        wait_cyc(HALF);
        for (int w = 0; w < 6; w++) begin
            spi_xfer_b(8'(8'h11 * (w + 1)), rxb);
            chk("b miso", 32'(rxb), 32'h5A);
        end
        wait_cyc(HALF);
        bus_b.spi_cs = 1'b1;
        wait_cyc(2 * HALF);
        chk("b strobes", 32'(n_strobe_b - s0), 32'd6);
        chk("b idx0", 32'(idx_log_b[s0]),   32'd0);
        chk("b idx1", 32'(idx_log_b[s0+1]), 32'd1);
        chk("b idx2", 32'(idx_log_b[s0+2]), 32'd2);
        chk("b idx3", 32'(idx_log_b[s0+3]), 32'd3);
        chk("b idx4", 32'(idx_log_b[s0+4]), 32'd3);
        chk("b idx5", 32'(idx_log_b[s0+5]), 32'd3);
        chk("b rx0",  32'(rx_log_b[s0]),    32'h11);
        chk("b rx5",  32'(rx_log_b[s0+5]),  32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
